ifetch_burst_unit: RTL

//  Parametrised instruction-fetch front end. Issues line-sized AXI4 INCR read bursts from a fetch PC,

---
 rtl/ifetch_burst_unit.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ifetch_burst_unit.sv
// Instruction-fetch front end: issues line-sized AXI4 INCR read bursts from
// the fetch PC, unpacks each beat into 32-bit words and queues them in an
// instruction FIFO that feeds decode. Handles PC redirect (with in-flight
// burst drain) and halts after a read-response error until redirected.
module ifetch_burst_unit #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int ID_WIDTH    = 13,
  parameter int AXI_ID      = 0,
  parameter int BURST_BEATS = 8,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] entry,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_err
);

  localparam int IPB        = DATA_WIDTH / 32;
  localparam int IPL        = IPB * BURST_BEATS;
  localparam int LINE_BYTES = IPL * 4;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int BEAT_W     = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_MASK   = ~ADDR_WIDTH'(3);

  typedef enum logic [2:0] {IDLE, REQ, RECV, DRAIN, HALT} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [BEAT_W-1:0]     beat_idx;
  logic                  redir_pend;
  logic                  halt_pend;

  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [31:0]           mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc   [FIFO_DEPTH];
  logic                  mem_err  [FIFO_DEPTH];

  logic                  beat_err, rx_take, pop, can_issue;
  logic [OFF_W-1:0]      start_off;
  logic [IPB-1:0]        push_en;
  logic [PTR_W-1:0]      slot     [IPB];
  logic [OFF_W-1:0]      word_off [IPB];
  logic [CNT_W-1:0]      push_n;
  logic                  unused_rid;

  assign unused_rid    = ^m_axi_rid;

  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = req_addr;
  assign m_axi_arlen   = 8'(BURST_BEATS - 1);
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;

  assign beat_err  = (m_axi_rresp != 2'b00);
  // A beat is kept only in RECV and only when no redirect arrives with it.
  assign rx_take   = (state == RECV) && m_axi_rvalid && !redirect_valid;
  assign start_off = fetch_pc[OFF_W-1:0];
  assign can_issue = (CNT_W'(FIFO_DEPTH) - count) >= CNT_W'(IPL);
  assign pop       = inst_valid && inst_ready;

  assign inst_valid = (count != '0);
  assign inst_data  = mem_data[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];
  assign inst_err   = mem_err[rd_ptr];

  // Per-word keep mask and packed FIFO slot; dropped words only form a prefix.
  always_comb begin
    push_n = '0;
    for (int k = 0; k < IPB; k++) begin
      word_off[k] = OFF_W'((int'(beat_idx) * IPB + k) * 4);
      slot[k]     = PTR_W'(push_n);
      push_en[k]  = rx_take && (word_off[k] >= start_off);
      push_n      = push_n + CNT_W'(push_en[k]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and AXI handshake outputs.
  always_comb begin
    state_next    = state;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect_valid && can_issue) state_next = REQ;
      end
      REQ: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = (redirect_valid || redir_pend) ? DRAIN : RECV;
      end
      RECV: begin
        m_axi_rready = 1'b1;
        if (redirect_valid) begin
          state_next = (m_axi_rvalid && m_axi_rlast) ? IDLE : DRAIN;
        end else if (m_axi_rvalid) begin
          if (beat_err)         state_next = m_axi_rlast ? HALT : DRAIN;
          else if (m_axi_rlast) state_next = IDLE;
        end
      end
      DRAIN: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && m_axi_rlast)
          state_next = (halt_pend && !redirect_valid) ? HALT : IDLE;
      end
      HALT: begin
        if (redirect_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fetch PC, pending redirect/halt flags and beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= entry & PC_MASK;
      redir_pend <= 1'b0;
      halt_pend  <= 1'b0;
      beat_idx   <= '0;
    end else begin
      if (redirect_valid)
        fetch_pc <= redirect_pc & PC_MASK;
      else if (rx_take && m_axi_rlast && !beat_err)
        fetch_pc <= req_addr + ADDR_WIDTH'(LINE_BYTES);

      if (state == REQ && m_axi_arready)       redir_pend <= 1'b0;
      else if (state == REQ && redirect_valid) redir_pend <= 1'b1;

      if (redirect_valid)                                halt_pend <= 1'b0;
      else if (rx_take && beat_err && !m_axi_rlast)      halt_pend <= 1'b1;
      else if (state == DRAIN && m_axi_rvalid && m_axi_rlast) halt_pend <= 1'b0;

      if (state == REQ && m_axi_arready) beat_idx <= '0;
      else if (rx_take)                  beat_idx <= beat_idx + BEAT_W'(1);
    end
  end

  // Line address captured at request time so AR stays stable across redirects.
  always_ff @(posedge clk) begin
    if (state == IDLE && state_next == REQ) req_addr <= fetch_pc & LINE_MASK;
  end

  // FIFO storage: up to IPB words written per accepted beat.
  always_ff @(posedge clk) begin
    for (int k = 0; k < IPB; k++) begin
      if (push_en[k]) begin
        mem_data[wr_ptr + slot[k]] <= m_axi_rdata[32*k +: 32];
        mem_pc[wr_ptr + slot[k]]   <= req_addr | ADDR_WIDTH'(word_off[k]);
        mem_err[wr_ptr + slot[k]]  <= beat_err;
      end
    end
  end

  // FIFO occupancy and pointers; a redirect flushes and wins over a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (redirect_valid) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      count  <= count + push_n - CNT_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule
